stall: RTL and testbench

- Three-stage registered arithmetic pipeline computing E = 5·A + B·C + 2304, modulo 2^16.
- Accepts a new operand set (A, B, C) every clock; there is no valid/ready handshake.
- Exposes each stage's intermediate register (s1, s2, s3) for debug and observation.
- Used as a stand-alone datapath block whose result follows its inputs by a fixed latency.

---
 rtl/stall.sv | 57 +++++
 tb/tb_stall.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stall.sv
`default_nettype none
// ============================================================================
// Module   : stall
// Purpose  : Three-stage registered datapath, E = 5*A + B*C + 2304 (mod 2^16).
// Revision : 1.0 - initial release
// ============================================================================
module stall (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    output logic [15:0] s1,
    output logic [15:0] s2,
    output logic [15:0] s3,
    output logic [15:0] E
);

    localparam logic [15:0] c_OFFSET = 16'h0900;

    logic [15:0] w_a_x5;
    logic [15:0] w_bc;
    logic [15:0] w_sum;
    logic [15:0] w_res;

    logic [15:0] r_s1;
    logic [15:0] r_s2;
    logic [15:0] r_s3;
    logic [15:0] r_e;

    // 5*A as shift-add; the zero-extended operand keeps the sum from clipping.
    assign w_a_x5 = ({8'd0, A} << 2) + {8'd0, A};
    assign w_bc   = {8'd0, B} * {8'd0, C};
    assign w_sum  = r_s1 + r_s2;
    assign w_res  = r_s3 + c_OFFSET;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 16'd0;
            r_s2 <= 16'd0;
            r_s3 <= 16'd0;
            r_e  <= 16'd0;
        end else begin
            r_s1 <= w_a_x5;
            r_s2 <= w_bc;
            r_s3 <= w_sum;
            r_e  <= w_res;
        end
    end

    assign s1 = r_s1;
    assign s2 = r_s2;
    assign s3 = r_s3;
    assign E  = r_e;

endmodule
`default_nettype wire

// File: tb/tb_stall.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall
// Purpose  : Directed-vector and random self-checking bench for stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stall;

    logic        clk;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  C;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] s3;
    logic [15:0] E;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] s3;
        logic [15:0] e;
    } vec_t;

    localparam int c_NVEC = 9;
    vec_t tbl [c_NVEC];

    stall dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .s1  (s1),
        .s2  (s2),
        .s3  (s3),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        A = a;
        B = b;
        C = c;
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int v;
        v = (5 * int'(a) + int'(b) * int'(c) + 2304) % 65536;
        return v[15:0];
    endfunction

    initial begin
        logic [15:0] exp_q [$];
        logic [15:0] exp_e;
        logic [7:0]  ra, rb, rc;

        // Hand-computed vectors, streamed back to back.
        tbl[0] = '{8'd21,  8'd52,  8'd90,  16'd105,  16'd4680,  16'd4785,  16'd7089};
        tbl[1] = '{8'd1,   8'd1,   8'd1,   16'd5,    16'd1,     16'd6,     16'd2310};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   16'd0,    16'd0,     16'd0,     16'd2304};
        tbl[3] = '{8'd2,   8'd1,   8'd1,   16'd10,   16'd1,     16'd11,    16'd2315};
        tbl[4] = '{8'd255, 8'd255, 8'd255, 16'd1275, 16'd65025, 16'd764,   16'd3068};
        tbl[5] = '{8'd100, 8'd200, 8'd200, 16'd500,  16'd40000, 16'd40500, 16'd42804};
        tbl[6] = '{8'd0,   8'd255, 8'd255, 16'd0,    16'd65025, 16'd65025, 16'd1793};
        tbl[7] = '{8'd255, 8'd0,   8'd0,   16'd1275, 16'd0,     16'd1275,  16'd3579};
        tbl[8] = '{8'd0,   8'd16,  8'd16,  16'd0,    16'd256,   16'd256,   16'd2560};

        // Reset then zeros.
        rst = 1'b0;
        drive(8'd7, 8'd9, 8'd11);
        step();
        drive(8'd0, 8'd0, 8'd0);
        step();
        check("reset_s1", s1, 16'd0);
        check("reset_s2", s2, 16'd0);
        check("reset_s3", s3, 16'd0);
        check("reset_E",  E,  16'd0);
        rst = 1'b1;
        step();
        step();
        step();
        check("refill_E", E, 16'd2304);
        check("refill_s3", s3, 16'd0);

        // Table stream: set i sampled at this edge; s3 lags one set, E lags two.
        for (int i = 0; i < c_NVEC + 2; i++) begin
            if (i < c_NVEC) drive(tbl[i].a, tbl[i].b, tbl[i].c);
            else            drive(8'd0, 8'd0, 8'd0);
            step();
            if (i < c_NVEC) begin
                check($sformatf("tbl%0d_s1", i), s1, tbl[i].s1);
                check($sformatf("tbl%0d_s2", i), s2, tbl[i].s2);
            end
            if (i >= 1 && i - 1 < c_NVEC) check($sformatf("tbl%0d_s3", i - 1), s3, tbl[i - 1].s3);
            if (i >= 2) check($sformatf("tbl%0d_E", i - 2), E, tbl[i - 2].e);
        end

        // Mid-stream reset with (1,1,1) held continuously.
        drive(8'd1, 8'd1, 8'd1);
        step();
        step();
        step();
        check("mid_pre_E", E, 16'd2310);
        rst = 1'b0;
        step();
        check("mid_rst_s1", s1, 16'd0);
        check("mid_rst_s2", s2, 16'd0);
        check("mid_rst_s3", s3, 16'd0);
        check("mid_rst_E",  E,  16'd0);
        rst = 1'b1;
        step();
        check("mid_s1", s1, 16'd5);
        check("mid_s2", s2, 16'd1);
        step();
        check("mid_s3", s3, 16'd6);
        step();
        check("mid_E", E, 16'd2310);

        // Random stream; E must match the set sampled two edges earlier.
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 8'($urandom_range(0, 255));
                drive(ra, rb, rc);
                exp_q.push_back(model(ra, rb, rc));
            end
            step();
            if (i >= 2) begin
                exp_e = exp_q.pop_front();
                check($sformatf("rand%0d_E", i - 2), E, exp_e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
